// File: rtl/fnb_ctrl.sv
// Pipeline flush-and-bubble controller: jump redirect, load-use bubble, divider and data-bus stalls.
// Define FNB_STALL_CNT_EN to add the stall/flush cycle counters and their ports.
module fnb_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_jump_i,
    input  logic [31:0] ex_jump_addr_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        id_rs1_re_i,
    input  logic        id_rs2_re_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        ex_load_i,
    input  logic        ex_div_start_i,
    input  logic        div_done_i,
    input  logic        mem_req_i,
    input  logic        mem_ready_i,
    output logic        fnb_flush_if_id_o,
    output logic        fnb_flush_id_ex_o,
    output logic        fnb_hold_pc_o,
    output logic        fnb_hold_if_id_o,
    output logic        fnb_hold_id_ex_o,
    output logic        fnb_hold_ex_mem_o,
    output logic        fnb_jump_o,
    output logic [31:0] fnb_jump_addr_o,
    output logic        fnb_div_timeout_o,
    output logic [1:0]  fnb_state_o
`ifdef FNB_STALL_CNT_EN
    ,
    output logic [31:0] fnb_stall_cnt_o,
    output logic [31:0] fnb_flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_WAIT = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam logic [5:0] DIV_LIMIT = 6'd40;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        load_use;
    logic        mem_stall;
    logic        div_expired;

    assign load_use = ex_load_i && (ex_rd_addr_i != 5'd0) &&
                      ((id_rs1_re_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                       (id_rs2_re_i && (id_rs2_addr_i == ex_rd_addr_i)));
    assign mem_stall   = mem_req_i && !mem_ready_i;
    assign div_expired = (cnt_q == DIV_LIMIT);
    assign fnb_state_o = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                end else if (ex_div_start_i) begin
                    state_d = DIV_WAIT;
                    cnt_d   = 6'd0;
                end
            end
            DIV_WAIT: begin
                // Done and expiry share one exit; done only differs in suppressing the pulse.
                if (div_done_i || div_expired) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        logic flush_if_id, flush_id_ex, hold_pc, hold_if_id, hold_id_ex, hold_ex_mem;
        flush_if_id       = 1'b0;
        flush_id_ex       = 1'b0;
        hold_pc           = 1'b0;
        hold_if_id        = 1'b0;
        hold_id_ex        = 1'b0;
        hold_ex_mem       = 1'b0;
        fnb_jump_o        = 1'b0;
        fnb_jump_addr_o   = 32'd0;
        fnb_div_timeout_o = 1'b0;
        // Outputs are combinational on inputs in IDLE, so reset must gate them directly.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (mem_stall) begin
                        hold_pc     = 1'b1;
                        hold_if_id  = 1'b1;
                        hold_id_ex  = 1'b1;
                        hold_ex_mem = 1'b1;
                    end else if (ex_jump_i) begin
                        fnb_jump_o      = 1'b1;
                        fnb_jump_addr_o = ex_jump_addr_i;
                        flush_if_id     = 1'b1;
                        flush_id_ex     = 1'b1;
                    end else if (load_use) begin
                        hold_pc     = 1'b1;
                        hold_if_id  = 1'b1;
                        flush_id_ex = 1'b1;
                    end
                end
                DIV_WAIT: begin
                    hold_pc           = 1'b1;
                    hold_if_id        = 1'b1;
                    hold_id_ex        = 1'b1;
                    fnb_div_timeout_o = div_expired && !div_done_i;
                end
                MEM_WAIT: begin
                    hold_pc     = 1'b1;
                    hold_if_id  = 1'b1;
                    hold_id_ex  = 1'b1;
                    hold_ex_mem = 1'b1;
                end
                default: ;
            endcase
        end
        fnb_flush_if_id_o = flush_if_id;
        fnb_flush_id_ex_o = flush_id_ex;
        fnb_hold_pc_o     = hold_pc;
        fnb_hold_if_id_o  = hold_if_id && !flush_if_id;
        fnb_hold_id_ex_o  = hold_id_ex && !flush_id_ex;
        fnb_hold_ex_mem_o = hold_ex_mem;
    end

`ifdef FNB_STALL_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (fnb_hold_pc_o) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (fnb_jump_o)    flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign fnb_stall_cnt_o = stall_cnt_q;
    assign fnb_flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fnb_ctrl.sv
// Bench for fnb_ctrl: IDLE vector table, hand-written stall/reset sequences, randomized run vs model.
// Define FNB_STALL_CNT_EN to also check the cycle counters.
module tb_fnb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_jump_i;
    logic [31:0] ex_jump_addr_i;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
    logic        id_rs1_re_i, id_rs2_re_i, ex_load_i;
    logic        ex_div_start_i, div_done_i, mem_req_i, mem_ready_i;
    logic        fnb_flush_if_id_o, fnb_flush_id_ex_o, fnb_hold_pc_o, fnb_hold_if_id_o;
    logic        fnb_hold_id_ex_o, fnb_hold_ex_mem_o, fnb_jump_o, fnb_div_timeout_o;
    logic [31:0] fnb_jump_addr_o;
    logic [1:0]  fnb_state_o;
`ifdef FNB_STALL_CNT_EN
    logic [31:0] fnb_stall_cnt_o, fnb_flush_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fnb_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .ex_jump_i         (ex_jump_i),
        .ex_jump_addr_i    (ex_jump_addr_i),
        .id_rs1_addr_i     (id_rs1_addr_i),
        .id_rs2_addr_i     (id_rs2_addr_i),
        .id_rs1_re_i       (id_rs1_re_i),
        .id_rs2_re_i       (id_rs2_re_i),
        .ex_rd_addr_i      (ex_rd_addr_i),
        .ex_load_i         (ex_load_i),
        .ex_div_start_i    (ex_div_start_i),
        .div_done_i        (div_done_i),
        .mem_req_i         (mem_req_i),
        .mem_ready_i       (mem_ready_i),
        .fnb_flush_if_id_o (fnb_flush_if_id_o),
        .fnb_flush_id_ex_o (fnb_flush_id_ex_o),
        .fnb_hold_pc_o     (fnb_hold_pc_o),
        .fnb_hold_if_id_o  (fnb_hold_if_id_o),
        .fnb_hold_id_ex_o  (fnb_hold_id_ex_o),
        .fnb_hold_ex_mem_o (fnb_hold_ex_mem_o),
        .fnb_jump_o        (fnb_jump_o),
        .fnb_jump_addr_o   (fnb_jump_addr_o),
        .fnb_div_timeout_o (fnb_div_timeout_o),
        .fnb_state_o       (fnb_state_o)
`ifdef FNB_STALL_CNT_EN
        ,
        .fnb_stall_cnt_o   (fnb_stall_cnt_o),
        .fnb_flush_cnt_o   (fnb_flush_cnt_o)
`endif
    );

    // Flag order: flush_if_id, flush_id_ex, hold_pc, hold_if_id, hold_id_ex, hold_ex_mem, jump, timeout.
    localparam logic [7:0] F_NONE  = 8'b0000_0000;
    localparam logic [7:0] F_JUMP  = 8'b1100_0010;
    localparam logic [7:0] F_LU    = 8'b0111_0000;
    localparam logic [7:0] F_DIV   = 8'b0011_1000;
    localparam logic [7:0] F_MEM   = 8'b0011_1100;

    typedef struct {
        logic        jump;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic        load;
        logic [4:0]  rs1;
        logic        re1;
        logic [4:0]  rs2;
        logic        re2;
        logic        mreq;
        logic        mrdy;
        logic [7:0]  want_flags;
        logic [31:0] want_addr;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [7:0] flags();
        return {fnb_flush_if_id_o, fnb_flush_id_ex_o, fnb_hold_pc_o, fnb_hold_if_id_o,
                fnb_hold_id_ex_o, fnb_hold_ex_mem_o, fnb_jump_o, fnb_div_timeout_o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic clear_inputs();
        ex_jump_i      = 1'b0;
        ex_jump_addr_i = 32'd0;
        id_rs1_addr_i  = 5'd0;
        id_rs2_addr_i  = 5'd0;
        id_rs1_re_i    = 1'b0;
        id_rs2_re_i    = 1'b0;
        ex_rd_addr_i   = 5'd0;
        ex_load_i      = 1'b0;
        ex_div_start_i = 1'b0;
        div_done_i     = 1'b0;
        mem_req_i      = 1'b0;
        mem_ready_i    = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int holds, tmo, tmo_k, jumps;
        int mode, div_since, cyc;
        logic [7:0]  want_f;
        logic [31:0] want_a;
        logic        lu;
        int stall_cnt, flush_cnt;

        vecs[0] = '{1'b0, 32'h0,         5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, F_NONE, 32'h0};
        vecs[1] = '{1'b1, 32'h0000_0100, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, F_JUMP, 32'h100};
        vecs[2] = '{1'b0, 32'h0,         5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, F_LU,   32'h0};
        vecs[3] = '{1'b0, 32'h0,         5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, F_NONE, 32'h0};
        vecs[4] = '{1'b0, 32'h0,         5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, F_NONE, 32'h0};
        vecs[5] = '{1'b0, 32'h0,         5'd7, 1'b1, 5'd7, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, F_LU,   32'h0};
        vecs[6] = '{1'b0, 32'h0,         5'd7, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, F_NONE, 32'h0};
        vecs[7] = '{1'b1, 32'hDEAD_BEEC, 5'd3, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, F_JUMP, 32'hDEAD_BEEC};
        vecs[8] = '{1'b1, 32'h0000_0040, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, F_JUMP, 32'h40};
        vecs[9] = '{1'b0, 32'h0,         5'd9, 1'b1, 5'd1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1, F_LU,   32'h0};

        // Reset state, with a jump driven to show reset gates the combinational path.
        clear_inputs();
        rst            = 1'b1;
        ex_jump_i      = 1'b1;
        ex_jump_addr_i = 32'h1234;
        #1;
        check("reset_flags", {24'd0, flags()}, {24'd0, F_NONE});
        check("reset_addr", fnb_jump_addr_o, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();

        // IDLE combinational vectors; none of these leave IDLE.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ex_jump_i      = vecs[i].jump;
            ex_jump_addr_i = vecs[i].addr;
            ex_rd_addr_i   = vecs[i].rd;
            ex_load_i      = vecs[i].load;
            id_rs1_addr_i  = vecs[i].rs1;
            id_rs1_re_i    = vecs[i].re1;
            id_rs2_addr_i  = vecs[i].rs2;
            id_rs2_re_i    = vecs[i].re2;
            mem_req_i      = vecs[i].mreq;
            mem_ready_i    = vecs[i].mrdy;
            #1;
            check($sformatf("vec%0d_flags", i), {24'd0, flags()}, {24'd0, vecs[i].want_flags});
            check($sformatf("vec%0d_addr", i), fnb_jump_addr_o, vecs[i].want_addr);
        end

        // Divide completing: start, ten quiet wait cycles, done on the eleventh.
        @(negedge clk);
        clear_inputs();
        ex_div_start_i = 1'b1;
        #1;
        check("div_start_cycle", {24'd0, flags()}, {24'd0, F_NONE});
        @(negedge clk);
        ex_div_start_i = 1'b0;
        holds = 0;
        tmo   = 0;
        for (int k = 1; k <= 30; k++) begin
            div_done_i = (k == 11);
            #1;
            if (fnb_hold_pc_o) holds++;
            if (fnb_div_timeout_o) tmo++;
            if (k == 1) check("div_wait_flags", {24'd0, flags()}, {24'd0, F_DIV});
            if (k == 12) check("div_release_flags", {24'd0, flags()}, {24'd0, F_NONE});
            @(negedge clk);
        end
        check("div_hold_cycles", holds, 11);
        check("div_no_timeout", tmo, 0);

        // Divide never completing: timeout pulse after 40 counted cycles.
        clear_inputs();
        ex_div_start_i = 1'b1;
        @(negedge clk);
        ex_div_start_i = 1'b0;
        holds = 0;
        tmo   = 0;
        tmo_k = 0;
        for (int k = 1; k <= 80; k++) begin
            #1;
            if (fnb_hold_pc_o) holds++;
            if (fnb_div_timeout_o) begin
                tmo++;
                tmo_k = k;
            end
            @(negedge clk);
        end
        check("tmo_hold_cycles", holds, 41);
        check("tmo_pulses", tmo, 1);
        check("tmo_cycle", tmo_k, 41);

        // Bus stall for three cycles with a jump pending: holds only, jump deferred.
        holds = 0;
        jumps = 0;
        for (int k = 0; k < 6; k++) begin
            mem_req_i      = (k < 4);
            mem_ready_i    = (k == 3);
            ex_jump_i      = (k < 4);
            ex_jump_addr_i = 32'h200;
            #1;
            if (k == 0) check("mem_entry_flags", {24'd0, flags()}, {24'd0, F_MEM});
            if (flags() == F_MEM) holds++;
            if (fnb_jump_o) jumps++;
            @(negedge clk);
        end
        check("mem_hold_cycles", holds, 4);
        check("mem_no_jump", jumps, 0);

        // Reset landing in the middle of a bus stall.
        clear_inputs();
        mem_req_i = 1'b1;
        @(negedge clk);
        mem_req_i      = 1'b0;
        ex_jump_i      = 1'b1;
        ex_jump_addr_i = 32'h300;
        #1;
        check("mem_wait_flags", {24'd0, flags()}, {24'd0, F_MEM});
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_flags", {24'd0, flags()}, {24'd0, F_NONE});
        check("rst_mid_addr", fnb_jump_addr_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        #1;
        check("post_rst_idle", {24'd0, flags()}, {24'd0, F_NONE});

        // Randomized run against a model built from the controller's rules.
        mode      = 0;
        div_since = 0;
        stall_cnt = 0;
        flush_cnt = 0;
        for (cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            ex_jump_i      = ($urandom_range(0, 4) == 0);
            ex_jump_addr_i = $urandom;
            id_rs1_addr_i  = 5'($urandom_range(0, 3));
            id_rs2_addr_i  = 5'($urandom_range(0, 3));
            id_rs1_re_i    = 1'($urandom_range(0, 1));
            id_rs2_re_i    = 1'($urandom_range(0, 1));
            ex_rd_addr_i   = 5'($urandom_range(0, 3));
            ex_load_i      = 1'($urandom_range(0, 1));
            ex_div_start_i = ($urandom_range(0, 9) == 0);
            div_done_i     = ($urandom_range(0, 24) == 0);
            mem_req_i      = ($urandom_range(0, 4) == 0);
            mem_ready_i    = 1'($urandom_range(0, 1));
            #1;
            lu = ex_load_i && ex_rd_addr_i != 0 &&
                 ((id_rs1_re_i && id_rs1_addr_i == ex_rd_addr_i) ||
                  (id_rs2_re_i && id_rs2_addr_i == ex_rd_addr_i));
            want_f = F_NONE;
            want_a = 32'h0;
            if (mode == 0) begin
                if (mem_req_i && !mem_ready_i) want_f = F_MEM;
                else if (ex_jump_i) begin
                    want_f = F_JUMP;
                    want_a = ex_jump_addr_i;
                end else if (lu) want_f = F_LU;
            end else if (mode == 1) begin
                want_f = F_DIV;
                if ((cyc - div_since) == 40 && !div_done_i) want_f[0] = 1'b1;
            end else begin
                want_f = F_MEM;
            end
            check($sformatf("rand%0d_flags", cyc), {24'd0, flags()}, {24'd0, want_f});
            check($sformatf("rand%0d_addr", cyc), fnb_jump_addr_o, want_a);
            if (want_f[5]) stall_cnt++;
            if (want_f[1]) flush_cnt++;
            if (mode == 0) begin
                if (mem_req_i && !mem_ready_i) mode = 2;
                else if (ex_div_start_i) begin
                    mode      = 1;
                    div_since = cyc + 1;
                end
            end else if (mode == 1) begin
                if (div_done_i || (cyc - div_since) == 40) mode = 0;
            end else if (mem_ready_i) begin
                mode = 0;
            end
        end
        @(negedge clk);
        clear_inputs();
`ifdef FNB_STALL_CNT_EN
        #1;
        check("stall_cnt", fnb_stall_cnt_o, stall_cnt);
        check("flush_cnt", fnb_flush_cnt_o, flush_cnt);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fnb_ctrl.md
FNB_CTRL -- requirements
Module: fnb_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  pipeline clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: ex_jump_i  input  1  branch taken or jump resolved in EX.
REQ-004 SHALL have port: ex_jump_addr_i  input  32  redirect target.
REQ-005 SHALL have ports: id_rs1_addr_i, id_rs2_addr_i  input  5 each  ID source registers; id_rs1_re_i, id_rs2_re_i  input  1 each  read enables.
REQ-006 SHALL have ports: ex_rd_addr_i  input  5  EX destination; ex_load_i  input  1  EX holds a load.
REQ-007 SHALL have ports: ex_div_start_i  input  1  divide issued; div_done_i  input  1  divider result valid.
REQ-008 SHALL have ports: mem_req_i  input  1  MEM data-bus request; mem_ready_i  input  1  bus ready.
REQ-009 SHALL have outputs, 1 bit each: fnb_flush_if_id_o, fnb_flush_id_ex_o, fnb_hold_pc_o, fnb_hold_if_id_o, fnb_hold_id_ex_o, fnb_hold_ex_mem_o, fnb_jump_o.
REQ-010 SHALL have outputs: fnb_jump_addr_o  32  PC redirect target; fnb_div_timeout_o  1  one-cycle timeout pulse.

Function
REQ-011 SHALL implement FSM states IDLE, DIV_WAIT, MEM_WAIT.
REQ-012 SHALL in IDLE with ex_jump_i=1 assert fnb_jump_o, fnb_flush_if_id_o and fnb_flush_id_ex_o combinationally in the same cycle, with fnb_jump_addr_o=ex_jump_addr_i; otherwise fnb_jump_addr_o=0.
REQ-013 SHALL detect load-use in IDLE when ex_load_i=1, ex_rd_addr_i!=0 and ex_rd_addr_i matches an enabled ID source register.
REQ-014 SHALL on load-use assert fnb_hold_pc_o, fnb_hold_if_id_o and fnb_flush_id_ex_o for exactly that cycle (one bubble), with no state change.
REQ-015 SHALL give ex_jump_i priority over load-use; on a simultaneous event only the jump outputs assert.
REQ-016 SHALL move IDLE->DIV_WAIT on ex_div_start_i=1 and clear a 6-bit wait counter.
REQ-017 SHALL in DIV_WAIT assert fnb_hold_pc_o, fnb_hold_if_id_o and fnb_hold_id_ex_o, and increment the counter each cycle.
REQ-018 SHALL move DIV_WAIT->IDLE on div_done_i=1; the holds drop in the cycle after div_done_i.
REQ-019 SHALL when the counter reaches 40 without div_done_i pulse fnb_div_timeout_o for one cycle and return to IDLE; div_done_i in that same cycle takes priority and suppresses the pulse.
REQ-020 SHALL move IDLE->MEM_WAIT when mem_req_i=1 and mem_ready_i=0; MEM_WAIT asserts all four hold outputs and returns to IDLE in the cycle after mem_ready_i=1.
REQ-021 SHALL assert the MEM_WAIT holds combinationally in the entry cycle (mem_req_i=1 and mem_ready_i=0 in IDLE).
REQ-022 SHALL give MEM_WAIT entry priority over DIV_WAIT entry, jump and load-use; deferred events are re-evaluated in IDLE because EX is held.
REQ-023 SHALL ignore ex_jump_i, ex_div_start_i and load-use while in DIV_WAIT or MEM_WAIT.
REQ-024 SHALL never assert hold and flush on the same pipeline register in one cycle; flush wins.

Reset
REQ-025 SHALL on rst=1 immediately force state IDLE, clear the counter and drive every output to 0, including in mid-wait.
REQ-026 SHALL resume evaluation on the first rising clk edge after rst falls.

Configuration
REQ-027 SHALL, when FNB_STALL_CNT_EN is defined, add outputs fnb_stall_cnt_o[31:0] (cycles with fnb_hold_pc_o=1) and fnb_flush_cnt_o[31:0] (cycles with fnb_jump_o=1), both reset to 0 and wrapping from 0xFFFFFFFF to 0.
REQ-028 SHALL, when FNB_STALL_CNT_EN is undefined, omit both counters and their ports with otherwise identical behaviour.

Verification
REQ-029 SHALL cover: ex_jump_i=1 with ex_jump_addr_i=0x0000_0100 in IDLE -> same-cycle fnb_jump_o=1, fnb_jump_addr_o=0x100, both flushes=1.
REQ-030 SHALL cover: ex_load_i=1, ex_rd_addr_i=5, id_rs2_addr_i=5, id_rs2_re_i=1 -> one cycle hold_pc/hold_if_id/flush_id_ex; with ex_rd_addr_i=0 -> no stall.
REQ-031 SHALL cover: ex_div_start_i pulse, then div_done_i after 10 cycles -> holds for 11 cycles, then IDLE.
REQ-032 SHALL cover: ex_div_start_i with no div_done_i -> fnb_div_timeout_o pulses once after 40 counted cycles, then holds drop.
REQ-033 SHALL cover: mem_req_i=1 with mem_ready_i=0 for 3 cycles plus ex_jump_i=1 -> four holds for 4 cycles and no jump; rst=1 mid-MEM_WAIT -> all outputs 0 immediately.
